id_ex_pipe: RTL
===============

ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter XLEN, 32: datapath width.
REQ-002 Parameter CNT_W, 16: width of each performance counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 valid_d  in  1  decode stage holds a real instruction.
REQ-006 stall  in  1  hold all E-stage contents.
REQ-007 flush  in  1  insert bubble into E stage.
REQ-008 RegWriteD, MemWriteD, ResultSrcD, ALUSrcD, BranchD  in  1 each  decoder control bits.
REQ-009 ALUOpD  in  2  decoder ALU operation class.
REQ-010 RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  XLEN each  operands, immediate, PCs.
REQ-011 Rs1D, Rs2D, RdD  in  5 each  register indices.
REQ-012 All D inputs above have matching E outputs (RegWriteE ... RdE), same widths, plus valid_e out 1.
REQ-013 stall_cnt, flush_cnt  out  CNT_W each  only present when ID_EX_PERF_CNT_EN is defined.

Function
REQ-014 Latency exactly one cycle: D inputs sampled at edge N appear on E outputs after edge N.
REQ-015 Per-edge priority: rst > flush > stall > load.
REQ-016 Load (no rst/flush/stall): every E output takes its D input; valid_e takes valid_d.
REQ-017 Stall: every E output keeps its value, including valid_e.
REQ-018 Flush: valid_e, RegWriteE, MemWriteE, BranchE go 0; other E outputs don't-care but implementation drives 0.
REQ-019 Flush and stall both asserted: flush wins; bubble inserted.
REQ-020 valid_d=0 on a load: all E control bits (RegWriteE, MemWriteE, BranchE) forced 0 regardless of D values; data fields load normally.
REQ-021 RegWriteE with RdE=0 passes unchanged; x0 suppression is the register file's job.
REQ-022 No combinational path from any input to any output.

Reset
REQ-023 On rst edge: all E outputs and valid_e = 0, counters = 0.
REQ-024 rst asserted mid-stall or with flush: reset values still result; stall/flush ignored that edge.
REQ-025 First load after rst release occurs on the first edge with rst=0.

Configuration
REQ-026 Macro ID_EX_PERF_CNT_EN: when defined, stall_cnt increments on each non-reset edge with stall=1 and flush=0; flush_cnt increments on each non-reset edge with flush=1.
REQ-027 Counters saturate at 2^CNT_W-1; no wrap.
REQ-028 Macro undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-029 Shared package holds opcode constants (load 0000011, store 0100011, R-type 0110011, branch 1100011), ALUOp encodings (00 add, 01 sub/branch, 10 funct-decoded) and a packed control-bundle typedef used by decoder and this block.
REQ-030 One sub-module, sat_counter (parameter CNT_W; inputs clk, rst, inc; output count), instantiated twice under ID_EX_PERF_CNT_EN.

Verification
REQ-031 Load: valid_d=1, RegWriteD=1, ALUOpD=10, RD1D=0x0000_0005, RdD=7 -> next cycle RegWriteE=1, ALUOpE=10, RD1E=0x0000_0005, RdE=7, valid_e=1.
REQ-032 Stall: load store (MemWriteD=1, ImmExtD=0x10), then stall=1 for 3 cycles with changing D inputs -> E outputs hold MemWriteE=1, ImmExtE=0x10 all 3 cycles; stall_cnt=3.
REQ-033 Flush over stall: stall=1, flush=1 with BranchE=1 held -> next cycle valid_e=0, BranchE=0, RegWriteE=0, MemWriteE=0; flush_cnt=1, stall_cnt unchanged.
REQ-034 Invalid slot: valid_d=0, RegWriteD=1, MemWriteD=1, RD2D=0xDEAD_BEEF -> RegWriteE=0, MemWriteE=0, RD2E=0xDEAD_BEEF, valid_e=0.
REQ-035 Reset mid-operation: rst=1 while stall=1 and valid_e=1 -> next cycle all outputs 0; counters 0.
REQ-036 Saturation (CNT_W=4): 20 consecutive flush cycles -> flush_cnt=15, stays 15.

Source files
------------

// File: rtl/id_ex_pipe_pkg.sv
// Shared decode/execute definitions: RV32 opcode constants, ALUOp encodings
// and the packed control bundle produced by the decoder and carried to E.
package id_ex_pipe_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned REG_IDX_W = 5;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic               reg_write;
        logic               mem_write;
        logic               result_src;
        logic               alu_src;
        logic               branch;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    // Clear the architecturally visible side-effect bits of a control bundle
    function automatic ctrl_t kill_ctrl(input ctrl_t c);
        ctrl_t r;
        r           = c;
        r.reg_write = 1'b0;
        r.mem_write = 1'b0;
        r.branch    = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/id_ex_pipe_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count qualifying edges, stop at the maximum value
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register. Priority per edge: rst > flush > stall > load.
// Optional stall/flush performance counters enabled by ID_EX_PERF_CNT_EN.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_d,
    input  logic            stall,
    input  logic            flush,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            ResultSrcD,
    input  logic            ALUSrcD,
    input  logic            BranchD,
    input  logic [1:0]      ALUOpD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    output logic            valid_e,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            ResultSrcE,
    output logic            ALUSrcE,
    output logic            BranchE,
    output logic [1:0]      ALUOpE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;
    logic  valid_q;

    assign ctrl_d = '{reg_write:  RegWriteD,
                      mem_write:  MemWriteD,
                      result_src: ResultSrcD,
                      alu_src:    ALUSrcD,
                      branch:     BranchD,
                      alu_op:     ALUOpD};

    // Pipeline register: reset/flush clear everything, stall holds, else load
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
        end else if (!stall) begin
            valid_q  <= valid_d;
            ctrl_q   <= valid_d ? ctrl_d : kill_ctrl(ctrl_d);
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            ImmExtE  <= ImmExtD;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
            RdE      <= RdD;
        end
    end

    assign valid_e    = valid_q;
    assign RegWriteE  = ctrl_q.reg_write;
    assign MemWriteE  = ctrl_q.mem_write;
    assign ResultSrcE = ctrl_q.result_src;
    assign ALUSrcE    = ctrl_q.alu_src;
    assign BranchE    = ctrl_q.branch;
    assign ALUOpE     = ctrl_q.alu_op;

`ifdef ID_EX_PERF_CNT_EN
    // A stall overridden by a flush is not counted as a stall
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall & ~flush),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (flush_cnt)
    );
`endif

endmodule
